rob_alloc_commit: RTL and testbench
===================================

Name: rob_alloc_commit

Overview:
- Reorder buffer. It allocates ROB IDs to decoded instructions and drives `currID`/`robfull` into the rename table.
- It accepts execution writebacks and exposes operand lookup ports for renamed sources.
- It retires completed entries strictly in program order, one per cycle.
- On retirement it emits the destination register, value and ROB ID to the register file and rename table.

Parameters:
- NUM_ENTRIES, 128, ROB depth; must equal 2**ROBID_BITS.
- ROBID_BITS, 7, ROB index width.
- VALUE_BITS, 32, result data width.
- REGID_BITS, 5, architectural register index width.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  decode requests an entry this cycle.
- alloc_dest  in  REGID_BITS  destination architectural register of allocating instruction.
- currID  out  ROBID_BITS  ID that the next accepted allocation receives (tail pointer).
- robfull  out  1  no free entry; allocation refused.
- rob_empty  out  1  no valid entries.
- wb_valid  in  1  execution result valid.
- wb_robid  in  ROBID_BITS  target entry of writeback.
- wb_value  in  VALUE_BITS  result value.
- rd1_robid, rd2_robid  in  ROBID_BITS  operand lookup IDs.
- rd1_ready, rd2_ready  out  1  looked-up entry valid and done.
- rd1_value, rd2_value  out  VALUE_BITS  looked-up result; 0 when not ready.
- commit_valid  out  1  one-cycle pulse, an entry retired.
- commit_regid  out  REGID_BITS  retired destination register.
- commit_value  out  VALUE_BITS  retired value.
- commit_robid  out  ROBID_BITS  retired ID; rename table clears its mapping if it still holds this ID.

Behaviour:
- State:
  - Per entry: valid, done, dest, value.
  - head and tail pointers, ROBID_BITS wide; wrap modulo NUM_ENTRIES naturally.
  - count, ROBID_BITS+1 wide.
- Outputs:
  - robfull = (count == NUM_ENTRIES); rob_empty = (count == 0); currID = tail. All combinational from registers.
- Allocate:
  - Condition: alloc_valid && !robfull.
  - At posedge: entry[tail] gets valid=1, done=0, dest=alloc_dest; tail++.
  - alloc_valid while robfull is dropped silently; decode must hold the instruction.
- Writeback:
  - Condition: wb_valid && entry[wb_robid].valid.
  - At posedge: done=1, value=wb_value.
  - Writeback to an invalid entry is ignored.
  - A repeated writeback to a done entry overwrites the value.
- Commit:
  - Condition: entry[head].valid && done, evaluated on registered state.
  - At posedge: commit_valid<=1 and commit_regid/value/robid <= entry[head] fields; entry[head].valid<=0; head++.
  - Otherwise commit_valid<=0 and the other commit outputs hold their previous values.
  - Latency: a writeback to head at edge N produces commit_valid high after edge N+1.
- Simultaneous events:
  - alloc + commit in the same cycle: count unchanged.
  - alloc while full + commit in the same cycle: alloc still refused, because robfull comes from pre-edge count.
  - Writeback and commit in the same cycle touch different entries (head must already be done); no conflict.
  - Writeback to the entry being allocated is impossible and is ignored.
- Read ports are combinational: ready = valid && done; value = done ? entry.value : 0.
- Reset (asynchronous, mid-operation included):
  - head = tail = count = 0; all valid/done = 0.
  - commit_valid = 0; commit_regid/value/robid = 0.
  - All in-flight instructions are discarded.
  - Outputs after reset: robfull=0, rob_empty=1, currID=0.

Optional Feature:
- Macro ROB_WB_BYPASS_EN.
- Defined: if wb_valid && wb_robid == rdX_robid && entry valid, then rdX_ready=1 and rdX_value=wb_value in the same cycle.
- Undefined: a lookup sees the result only from the cycle after the writeback edge.
- Commit timing is identical either way.

Decomposition:
- Package rob_pkg holds:
  - rob_entry_t packed struct {valid, done, dest, value};
  - localparams for widths;
  - typedefs robid_t and regid_t.
- One sub-module, rob_storage: entry array with one allocate write port, one writeback write port, one retire clear port, and three combinational read ports (head, rd1, rd2).
- Pointer/count logic and commit registers stay in the top.

Test Plan:
- Reset: drive rst=0 mid-stream with 5 entries in flight -> immediately rob_empty=1, robfull=0, currID=0, commit_valid=0; a subsequent writeback to ID 2 is ignored.
- In-order retire: allocate dest 3,4,5 as IDs 0,1,2; write back ID2=0x33 then ID1=0x22 then ID0=0x11 -> three consecutive commit_valid pulses (r3/0x11/ID0, r4/0x22/ID1, r5/0x33/ID2), none before ID0 completes.
- Full: 128 allocations -> robfull=1, currID=0; a 129th alloc_valid is refused. Write back ID0 -> after commit robfull=0 and the next alloc receives ID0.
- Wrap-around: cycle 300 instructions through with interleaved writebacks -> commit_robid sequence is 0..127,0..127,0..43; count never exceeds 128.
- Same-cycle alloc+commit at count=64 -> count stays 64, currID and head both advance by 1.
- Lookup: rd1_robid=5 with a writeback 0xABCD to ID5 this cycle -> rd1_ready=1, rd1_value=0xABCD same cycle with ROB_WB_BYPASS_EN; without it, 0/0 this cycle and 1/0xABCD next cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared widths, ID types and entry payload for the reorder buffer.
package rob_pkg;

  localparam int unsigned ROBID_BITS  = 7;
  localparam int unsigned NUM_ENTRIES = 2 ** ROBID_BITS;
  localparam int unsigned VALUE_BITS  = 32;
  localparam int unsigned REGID_BITS  = 5;
  localparam int unsigned COUNT_BITS  = ROBID_BITS + 1;

  typedef logic [ROBID_BITS-1:0] robid_t;
  typedef logic [REGID_BITS-1:0] regid_t;
  typedef logic [VALUE_BITS-1:0] value_t;
  typedef logic [COUNT_BITS-1:0] count_t;

  typedef struct packed {
    logic   valid;
    logic   done;
    regid_t dest;
    value_t value;
  } rob_entry_t;

endpackage

// File: rtl/rob_storage.sv
// ROB entry array: allocate, writeback and retire-clear write ports; head and two operand read ports.
// ROB_WB_BYPASS_EN forwards a same-cycle writeback onto the operand read ports.
module rob_storage
  import rob_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_alloc_en,
  input  robid_t     i_alloc_id,
  input  regid_t     i_alloc_dest,
  input  logic       i_wb_valid,
  input  robid_t     i_wb_id,
  input  value_t     i_wb_value,
  input  logic       i_clr_en,
  input  robid_t     i_head_id,
  output rob_entry_t o_head_c,
  input  robid_t     i_rd1_id,
  output logic       o_rd1_ready_c,
  output value_t     o_rd1_value_c,
  input  robid_t     i_rd2_id,
  output logic       o_rd2_ready_c,
  output value_t     o_rd2_value_c
);

  rob_entry_t r_mem [NUM_ENTRIES];

  // Writeback only lands on a live entry; allocate targets a free slot so ports never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) r_mem[i] <= '0;
    end else begin
      if (i_wb_valid && r_mem[i_wb_id].valid) begin
        r_mem[i_wb_id].done  <= 1'b1;
        r_mem[i_wb_id].value <= i_wb_value;
      end
      if (i_clr_en) r_mem[i_head_id].valid <= 1'b0;
      if (i_alloc_en) r_mem[i_alloc_id] <= '{valid: 1'b1, done: 1'b0, dest: i_alloc_dest, value: '0};
    end
  end

  assign o_head_c = r_mem[i_head_id];

  always_comb begin
    o_rd1_ready_c = r_mem[i_rd1_id].valid && r_mem[i_rd1_id].done;
    o_rd1_value_c = r_mem[i_rd1_id].done ? r_mem[i_rd1_id].value : '0;
    o_rd2_ready_c = r_mem[i_rd2_id].valid && r_mem[i_rd2_id].done;
    o_rd2_value_c = r_mem[i_rd2_id].done ? r_mem[i_rd2_id].value : '0;
`ifdef ROB_WB_BYPASS_EN
    if (i_wb_valid && (i_wb_id == i_rd1_id) && r_mem[i_rd1_id].valid) begin
      o_rd1_ready_c = 1'b1;
      o_rd1_value_c = i_wb_value;
    end
    if (i_wb_valid && (i_wb_id == i_rd2_id) && r_mem[i_rd2_id].valid) begin
      o_rd2_ready_c = 1'b1;
      o_rd2_value_c = i_wb_value;
    end
`endif
  end

endmodule

// File: rtl/rob_alloc_commit.sv
// Reorder buffer top: ID allocation, writeback, in-order single-entry retirement.
// Optional macro ROB_WB_BYPASS_EN enables same-cycle writeback forwarding on lookups.
module rob_alloc_commit
  import rob_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [REGID_BITS-1:0] alloc_dest,
  output logic [ROBID_BITS-1:0] currID,
  output logic                  robfull,
  output logic                  rob_empty,
  input  logic                  wb_valid,
  input  logic [ROBID_BITS-1:0] wb_robid,
  input  logic [VALUE_BITS-1:0] wb_value,
  input  logic [ROBID_BITS-1:0] rd1_robid,
  input  logic [ROBID_BITS-1:0] rd2_robid,
  output logic                  rd1_ready,
  output logic                  rd2_ready,
  output logic [VALUE_BITS-1:0] rd1_value,
  output logic [VALUE_BITS-1:0] rd2_value,
  output logic                  commit_valid,
  output logic [REGID_BITS-1:0] commit_regid,
  output logic [VALUE_BITS-1:0] commit_value,
  output logic [ROBID_BITS-1:0] commit_robid
);

  robid_t     r_head;
  robid_t     r_tail;
  count_t     r_count;
  logic       r_commit_valid;
  regid_t     r_commit_regid;
  value_t     r_commit_value;
  robid_t     r_commit_robid;
  rob_entry_t w_head_entry;
  logic       w_alloc;
  logic       w_commit;

  assign robfull   = (r_count == COUNT_BITS'(NUM_ENTRIES));
  assign rob_empty = (r_count == '0);
  assign currID    = r_tail;

  assign w_alloc  = alloc_valid && !robfull;
  assign w_commit = w_head_entry.valid && w_head_entry.done;

  rob_storage u_storage (
    .clk           (clk),
    .rst           (rst),
    .i_alloc_en    (w_alloc),
    .i_alloc_id    (r_tail),
    .i_alloc_dest  (alloc_dest),
    .i_wb_valid    (wb_valid),
    .i_wb_id       (wb_robid),
    .i_wb_value    (wb_value),
    .i_clr_en      (w_commit),
    .i_head_id     (r_head),
    .o_head_c      (w_head_entry),
    .i_rd1_id      (rd1_robid),
    .o_rd1_ready_c (rd1_ready),
    .o_rd1_value_c (rd1_value),
    .i_rd2_id      (rd2_robid),
    .o_rd2_ready_c (rd2_ready),
    .o_rd2_value_c (rd2_value)
  );

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + ROBID_BITS'(1);
      if (w_commit) r_head <= r_head + ROBID_BITS'(1);
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + COUNT_BITS'(1);
        2'b01:   r_count <= r_count - COUNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Retire payload holds its last value between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commit_valid <= 1'b0;
      r_commit_regid <= '0;
      r_commit_value <= '0;
      r_commit_robid <= '0;
    end else begin
      r_commit_valid <= w_commit;
      if (w_commit) begin
        r_commit_regid <= w_head_entry.dest;
        r_commit_value <= w_head_entry.value;
        r_commit_robid <= r_head;
      end
    end
  end

  assign commit_valid = r_commit_valid;
  assign commit_regid = r_commit_regid;
  assign commit_value = r_commit_value;
  assign commit_robid = r_commit_robid;

endmodule

// File: tb/tb_rob_alloc_commit.sv
// Directed self-checking bench for rob_alloc_commit (honours ROB_WB_BYPASS_EN for lookup expectations).
module tb_rob_alloc_commit;
  import rob_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic [6:0]  currID;
  logic        robfull, rob_empty;
  logic        wb_valid;
  logic [6:0]  wb_robid;
  logic [31:0] wb_value;
  logic [6:0]  rd1_robid, rd2_robid;
  logic        rd1_ready, rd2_ready;
  logic [31:0] rd1_value, rd2_value;
  logic        commit_valid;
  logic [4:0]  commit_regid;
  logic [31:0] commit_value;
  logic [6:0]  commit_robid;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rob_alloc_commit dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .currID(currID), .robfull(robfull), .rob_empty(rob_empty),
    .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_value(wb_value),
    .rd1_robid(rd1_robid), .rd2_robid(rd2_robid),
    .rd1_ready(rd1_ready), .rd2_ready(rd2_ready),
    .rd1_value(rd1_value), .rd2_value(rd2_value),
    .commit_valid(commit_valid), .commit_regid(commit_regid),
    .commit_value(commit_value), .commit_robid(commit_robid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit done_q [300];
  int n_alloc, n_wb, n_com, cyc;
  bit acc, do_wb, do_com;

  initial begin
    rst = 1'b0; alloc_valid = 1'b0; alloc_dest = '0;
    wb_valid = 1'b0; wb_robid = '0; wb_value = '0;
    rd1_robid = '0; rd2_robid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", rob_empty, 1); chk("rst_full", robfull, 0);
    chk("rst_currid", currID, 0); chk("rst_cv", commit_valid, 0);
    rst = 1'b1;

    // In-order retire: IDs 0..2, writebacks in reverse order
    alloc_valid = 1'b1;
    alloc_dest = 5'd3; step(); chk("alloc0_currid", currID, 1);
    alloc_dest = 5'd4; step();
    alloc_dest = 5'd5; step();
    alloc_valid = 1'b0;
    chk("alloc3_currid", currID, 3); chk("alloc3_empty", rob_empty, 0);
    wb_valid = 1'b1;
    wb_robid = 7'd2; wb_value = 32'h33; step(); chk("ooo_cv_a", commit_valid, 0);
    wb_robid = 7'd1; wb_value = 32'h22; step(); chk("ooo_cv_b", commit_valid, 0);
    wb_robid = 7'd0; wb_value = 32'h11; step(); chk("ooo_cv_c", commit_valid, 0);
    wb_valid = 1'b0;
    step();
    chk("c0_v", commit_valid, 1); chk("c0_reg", commit_regid, 3);
    chk("c0_val", commit_value, 32'h11); chk("c0_id", commit_robid, 0);
    step();
    chk("c1_v", commit_valid, 1); chk("c1_reg", commit_regid, 4);
    chk("c1_val", commit_value, 32'h22); chk("c1_id", commit_robid, 1);
    step();
    chk("c2_v", commit_valid, 1); chk("c2_reg", commit_regid, 5);
    chk("c2_val", commit_value, 32'h33); chk("c2_id", commit_robid, 2);
    step();
    chk("c3_v", commit_valid, 0); chk("c3_hold_reg", commit_regid, 5);
    chk("c3_empty", rob_empty, 1);

    // Lookup on ID5 while it is written back
    alloc_valid = 1'b1; alloc_dest = 5'd7;
    repeat (3) step();
    alloc_valid = 1'b0;
    rd1_robid = 7'd5; rd2_robid = 7'd4;
    wb_valid = 1'b1; wb_robid = 7'd5; wb_value = 32'hABCD;
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("lk_same_rdy", rd1_ready, 1); chk("lk_same_val", rd1_value, 32'hABCD);
`else
    chk("lk_same_rdy", rd1_ready, 0); chk("lk_same_val", rd1_value, 0);
`endif
    step();
    wb_valid = 1'b0;
    #1;
    chk("lk_next_rdy", rd1_ready, 1); chk("lk_next_val", rd1_value, 32'hABCD);
    chk("lk_rd2_rdy", rd2_ready, 0); chk("lk_rd2_val", rd2_value, 0);
    chk("lk_no_commit", commit_valid, 0);
    wb_valid = 1'b1;
    wb_robid = 7'd3; wb_value = 32'h1; step();
    wb_robid = 7'd4; wb_value = 32'h2; step();
    wb_valid = 1'b0;
    repeat (3) step();
    chk("lk_empty", rob_empty, 1); chk("lk_last_id", commit_robid, 5);
    chk("lk_last_val", commit_value, 32'hABCD); chk("lk_currid", currID, 6);

    // Asynchronous reset with entries in flight
    alloc_valid = 1'b1; alloc_dest = 5'd9;
    repeat (6) step();
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_robid = 7'd6; wb_value = 32'h77; step();
    wb_valid = 1'b0;
    step();
    chk("pre_rst_cv", commit_valid, 1); chk("pre_rst_id", commit_robid, 6);
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", rob_empty, 1); chk("arst_full", robfull, 0);
    chk("arst_currid", currID, 0); chk("arst_cv", commit_valid, 0);
    chk("arst_reg", commit_regid, 0); chk("arst_id", commit_robid, 0);
    step();
    rst = 1'b1;
    wb_valid = 1'b1; wb_robid = 7'd2; wb_value = 32'h99; step();
    wb_valid = 1'b0; rd1_robid = 7'd2;
    step();
    chk("arst_wb_cv", commit_valid, 0); chk("arst_wb_empty", rob_empty, 1);
    chk("arst_wb_rdy", rd1_ready, 0); chk("arst_wb_val", rd1_value, 0);

    // Fill to 128, refuse the 129th, free one slot
    alloc_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      alloc_dest = 5'(i);
      step();
    end
    chk("full_full", robfull, 1); chk("full_currid", currID, 0); chk("full_empty", rob_empty, 0);
    alloc_dest = 5'd30; step();
    chk("full_refuse_id", currID, 0); chk("full_refuse_full", robfull, 1);
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_robid = 7'd0; wb_value = 32'h100; step();
    wb_valid = 1'b0;
    step();
    chk("full_cv", commit_valid, 1); chk("full_c_id", commit_robid, 0);
    chk("full_c_reg", commit_regid, 0); chk("full_c_val", commit_value, 32'h100);
    chk("full_freed", robfull, 0);
    alloc_valid = 1'b1; alloc_dest = 5'd9; step();
    alloc_valid = 1'b0; rd1_robid = 7'd0;
    #1;
    chk("reuse_currid", currID, 1); chk("reuse_full", robfull, 1);
    chk("reuse_rdy", rd1_ready, 0); chk("reuse_val", rd1_value, 0);

    // Wrap-around: 300 instructions against an in-order model
    rst = 1'b0; step(); rst = 1'b1;
    n_alloc = 0; n_wb = 0; n_com = 0; cyc = 0;
    while (n_com < 300 && cyc < 3000) begin
      alloc_valid = (n_alloc < 300);
      alloc_dest  = 5'(n_alloc);
      acc    = alloc_valid && ((n_alloc - n_com) < 128);
      do_wb  = (n_wb < n_alloc) && (cyc >= 140) && (cyc % 4 != 1);
      do_com = (n_com < n_alloc) && done_q[n_com];
      wb_valid = do_wb; wb_robid = 7'(n_wb); wb_value = 32'(n_wb * 3 + 1);
      step();
      chk("wrap_cv", commit_valid, 32'(do_com));
      if (do_com) begin
        chk("wrap_id", commit_robid, 32'(n_com % 128));
        chk("wrap_val", commit_value, 32'(n_com * 3 + 1));
        n_com++;
      end
      if (do_wb) begin
        done_q[n_wb] = 1'b1;
        n_wb++;
      end
      if (acc) n_alloc++;
      chk("wrap_full", robfull, 32'((n_alloc - n_com) == 128));
      cyc++;
    end
    alloc_valid = 1'b0; wb_valid = 1'b0;
    chk("wrap_all_retired", 32'(n_com), 300);
    step();
    chk("wrap_empty", rob_empty, 1); chk("wrap_currid", currID, 44);

    // Alloc and commit in the same cycle at count 64
    alloc_valid = 1'b1; alloc_dest = 5'd2;
    repeat (64) step();
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_robid = 7'd44; wb_value = 32'h5A; step();
    wb_valid = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 5'd1; step();
    chk("sc_cv", commit_valid, 1); chk("sc_id", commit_robid, 44);
    chk("sc_val", commit_value, 32'h5A); chk("sc_currid", currID, 109);
    repeat (63) step();
    chk("sc_127_full", robfull, 0); chk("sc_127_currid", currID, 44);
    step();
    chk("sc_128_full", robfull, 1); chk("sc_128_currid", currID, 45);
    alloc_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
